// File: rtl/e_mdu_ctrl_if.sv
// E-stage multiply/divide unit bus: op request from the pipeline, busy and HI/LO back.
interface e_mdu_ctrl_if;
  logic        E_MDUStart;
  logic [3:0]  E_MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        E_MDUBusy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  modport master (
    output E_MDUStart, E_MDUOp, A, B,
    input  E_MDUBusy, E_HI, E_LO
  );

  modport slave (
    input  E_MDUStart, E_MDUOp, A, B,
    output E_MDUBusy, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU controller: fixed-latency MULT/DIV sequencing with HI/LO writeback.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module e_mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  e_mdu_ctrl_if.slave  mdu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } op_e;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [31:0]       a_q,     a_d;
  logic [31:0]       b_q,     b_d;
  logic [3:0]        op_q,    op_d;
  logic [31:0]       hi_q,    hi_d;
  logic [31:0]       lo_q,    lo_d;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: r = 1'b1;
`endif
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Datapath works only on latched operands so A/B may change freely while busy.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod, mul_res;
  logic        div_signed;
  logic [31:0] div_num, div_den, div_den_safe;
  logic [31:0] q_mag, r_mag, quot, rem;

  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD);
    mul_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    mul_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod       = mul_a * mul_b;
`ifdef MDU_MADD_EN
    if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
      mul_res = {hi_q, lo_q} + prod;
    end else begin
      mul_res = prod;
    end
`else
    mul_res = prod;
`endif
  end

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000.
  always_comb begin
    div_signed   = (op_q == OP_DIV);
    div_num      = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    div_den      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    div_den_safe = (div_den == 32'd0) ? 32'd1 : div_den;
    q_mag        = div_num / div_den_safe;
    r_mag        = div_num % div_den_safe;
    quot         = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    rem          = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (mdu.E_MDUStart) begin
          if (is_mul_op(mdu.E_MDUOp)) begin
            a_d     = mdu.A;
            b_d     = mdu.B;
            op_d    = mdu.E_MDUOp;
            cnt_d   = MULT_LOAD;
            state_d = MUL;
          end else if (is_div_op(mdu.E_MDUOp)) begin
            a_d     = mdu.A;
            b_d     = mdu.B;
            op_d    = mdu.E_MDUOp;
            cnt_d   = DIV_LOAD;
            state_d = DIV;
          end else if (mdu.E_MDUOp == OP_MTHI) begin
            hi_d = mdu.A;
          end else if (mdu.E_MDUOp == OP_MTLO) begin
            lo_d = mdu.A;
          end
        end
      end

      MUL: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d        = '0;
          state_d      = IDLE;
          {hi_d, lo_d} = mul_res;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DIV: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.E_MDUBusy = (state_q != IDLE);
  assign mdu.E_HI      = hi_q;
  assign mdu.E_LO      = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: scoreboarded MULT/DIV results, busy length and control corner cases.
module tb_e_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  e_mdu_ctrl_if bus ();

  e_mdu_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m, lo_m;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t        e;
    logic [63:0] p;
    int          sa, sbv;
    e.hi = hi; e.lo = lo; e.cyc = 0;
    case (op)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {e.hi, e.lo} = p; e.cyc = MC; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = p; e.cyc = MC; end
      4'd3: begin
        e.cyc = DC;
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'd0;
          end else begin
            sa = a; sbv = b;
            e.lo = sa / sbv; e.hi = sa % sbv;
          end
        end
      end
      4'd4: begin e.cyc = DC; if (b != 32'd0) begin e.lo = a / b; e.hi = a % b; end end
      4'd5: e.hi = a;
      4'd6: e.lo = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = longint'($signed(a)) * longint'($signed(b)); {e.hi, e.lo} = {hi, lo} + p; e.cyc = MC; end
      4'd8: begin p = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = {hi, lo} + p; e.cyc = MC; end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Called at a negedge; holds the request for one cycle, then scrambles the operands.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.E_MDUStart = 1'b1;
    bus.E_MDUOp    = op;
    bus.A          = a;
    bus.B          = b;
    @(negedge clk);
    bus.E_MDUStart = 1'b0;
    bus.E_MDUOp    = 4'd0;
    bus.A          = $urandom;
    bus.B          = $urandom;
  endtask

  task automatic wait_idle(output int cyc, output bit stable);
    logic [31:0] h0, l0;
    h0 = bus.E_HI; l0 = bus.E_LO;
    cyc = 0; stable = 1'b1;
    while (bus.E_MDUBusy === 1'b1 && cyc < 200) begin
      cyc++;
      if (bus.E_HI !== h0 || bus.E_LO !== l0) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.E_MDUStart = 1'b0; bus.E_MDUOp = 4'd0; bus.A = '0; bus.B = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.E_MDUBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.E_MDUBusy); end
    checks++; if (bus.E_HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.E_HI); end
    checks++; if (bus.E_LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.E_LO); end
    reset_n = 1'b1;
    @(negedge clk);
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_mt;
    start_op(4'd5, 32'h11, 32'hDEAD);
    checks++; if (bus.E_HI !== 32'h11 || bus.E_MDUBusy !== 1'b0)
      begin errors++; $display("FAIL mthi got hi=%h busy=%0b want hi=11 busy=0", bus.E_HI, bus.E_MDUBusy); end
    start_op(4'd6, 32'h22, 32'hBEEF);
    checks++; if (bus.E_LO !== 32'h22 || bus.E_HI !== 32'h11 || bus.E_MDUBusy !== 1'b0)
      begin errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%0b want 11/22/0", bus.E_HI, bus.E_LO, bus.E_MDUBusy); end
    hi_m = 32'h11; lo_m = 32'h22;
  endtask

  task automatic test_mult;
    logic [3:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    int          cyc;
    bit          stable;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        op = 4'd1; a = 32'hFFFF_FFFE; b = 32'd3;
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA; e.cyc = 5;
      end else begin
        op = (i % 2 == 1) ? 4'd1 : 4'd2; a = $urandom; b = $urandom;
        e = model(op, a, b, hi_m, lo_m);
      end
      sb.push_back(e);
      start_op(op, a, b);
      wait_idle(cyc, stable);
      e = sb.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL mult_busy[%0d] got %0d cycles want %0d", i, cyc, e.cyc); end
      checks++; if (!stable) begin errors++; $display("FAIL mult_stable[%0d] got changing HI/LO want stable", i); end
      checks++; if (bus.E_HI !== e.hi || bus.E_LO !== e.lo)
        begin errors++; $display("FAIL mult_res[%0d] got %h_%h want %h_%h", i, bus.E_HI, bus.E_LO, e.hi, e.lo); end
      hi_m = e.hi; lo_m = e.lo;
    end
  endtask

  task automatic test_div;
    logic [3:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    int          cyc;
    bit          stable;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin op = 4'd4; a = 32'd100; b = 32'd7; e.lo = 32'd14; e.hi = 32'd2; e.cyc = 10; end
        1: begin op = 4'd3; a = 32'hFFFF_FFF9; b = 32'd2; e.lo = 32'hFFFF_FFFD; e.hi = 32'hFFFF_FFFF; e.cyc = 10; end
        2: begin op = 4'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; e.lo = 32'h8000_0000; e.hi = 32'd0; e.cyc = 10; end
        default: begin
          op = (i % 2 == 1) ? 4'd3 : 4'd4;
          a  = $urandom;
          b  = $urandom_range(1, 1000);
          if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
          e  = model(op, a, b, hi_m, lo_m);
        end
      endcase
      sb.push_back(e);
      start_op(op, a, b);
      wait_idle(cyc, stable);
      e = sb.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL div_busy[%0d] got %0d cycles want %0d", i, cyc, e.cyc); end
      checks++; if (!stable) begin errors++; $display("FAIL div_stable[%0d] got changing HI/LO want stable", i); end
      checks++; if (bus.E_HI !== e.hi || bus.E_LO !== e.lo)
        begin errors++; $display("FAIL div_res[%0d] got %h_%h want %h_%h", i, bus.E_HI, bus.E_LO, e.hi, e.lo); end
      hi_m = e.hi; lo_m = e.lo;
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   cyc;
    bit   stable;
    start_op(4'd5, 32'h11, 32'h0);
    start_op(4'd6, 32'h22, 32'h0);
    e.hi = 32'h11; e.lo = 32'h22; e.cyc = 10;
    sb.push_back(e);
    start_op(4'd3, 32'd5, 32'd0);
    wait_idle(cyc, stable);
    e = sb.pop_front();
    checks++; if (cyc != e.cyc) begin errors++; $display("FAIL divzero_busy got %0d cycles want %0d", cyc, e.cyc); end
    checks++; if (bus.E_HI !== e.hi || bus.E_LO !== e.lo)
      begin errors++; $display("FAIL divzero_res got %h_%h want %h_%h", bus.E_HI, bus.E_LO, e.hi, e.lo); end
    hi_m = e.hi; lo_m = e.lo;
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int   cyc;
    bit   stable;
    e = model(4'd2, 32'h1234_5678, 32'h9ABC_DEF0, hi_m, lo_m);
    sb.push_back(e);
    start_op(4'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    bus.E_MDUStart = 1'b1; bus.E_MDUOp = 4'd5; bus.A = 32'h55;
    @(negedge clk);
    bus.E_MDUStart = 1'b0; bus.E_MDUOp = 4'd0; bus.A = $urandom;
    wait_idle(cyc, stable);
    e = sb.pop_front();
    checks++; if (cyc + 2 != e.cyc) begin errors++; $display("FAIL ignore_busy got %0d cycles want %0d", cyc + 2, e.cyc); end
    checks++; if (!stable) begin errors++; $display("FAIL ignore_stable got changing HI/LO want stable"); end
    checks++; if (bus.E_HI !== e.hi || bus.E_LO !== e.lo)
      begin errors++; $display("FAIL ignore_res got %h_%h want %h_%h", bus.E_HI, bus.E_LO, e.hi, e.lo); end
    hi_m = e.hi; lo_m = e.lo;
  endtask

  task automatic test_nop;
    logic [3:0] op;
    for (int i = 0; i < 16; i++) begin
      if (i >= 1 && i <= 8) continue;
      op = 4'(i);
      start_op(op, $urandom, $urandom);
      checks++; if (bus.E_MDUBusy !== 1'b0 || bus.E_HI !== hi_m || bus.E_LO !== lo_m)
        begin errors++; $display("FAIL nop[%0d] got busy=%0b %h_%h want 0 %h_%h", i, bus.E_MDUBusy, bus.E_HI, bus.E_LO, hi_m, lo_m); end
    end
  endtask

  task automatic test_madd;
    exp_t e;
    int   cyc;
    bit   stable;
    start_op(4'd5, 32'd0, 32'd0);
    start_op(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
    e.hi = 32'd1; e.lo = 32'd0; e.cyc = MC;
`else
    e.hi = 32'd0; e.lo = 32'hFFFF_FFFF; e.cyc = 0;
`endif
    sb.push_back(e);
    start_op(4'd8, 32'd1, 32'd1);
    wait_idle(cyc, stable);
    e = sb.pop_front();
    checks++; if (cyc != e.cyc) begin errors++; $display("FAIL maddu_busy got %0d cycles want %0d", cyc, e.cyc); end
    checks++; if (bus.E_HI !== e.hi || bus.E_LO !== e.lo)
      begin errors++; $display("FAIL maddu_res got %h_%h want %h_%h", bus.E_HI, bus.E_LO, e.hi, e.lo); end
    hi_m = e.hi; lo_m = e.lo;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops[4];
    logic [31:0] a, b;
    exp_t        e;
    int          cyc;
    bit          stable;
    ops[0] = 4'd1; ops[1] = 4'd4; ops[2] = 4'd2; ops[3] = 4'd3;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom_range(1, 50000);
      e = model(ops[i], a, b, hi_m, lo_m);
      sb.push_back(e);
      start_op(ops[i], a, b);
      wait_idle(cyc, stable);
      e = sb.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL b2b_busy[%0d] got %0d cycles want %0d", i, cyc, e.cyc); end
      checks++; if (bus.E_HI !== e.hi || bus.E_LO !== e.lo)
        begin errors++; $display("FAIL b2b_res[%0d] got %h_%h want %h_%h", i, bus.E_HI, bus.E_LO, e.hi, e.lo); end
      hi_m = e.hi; lo_m = e.lo;
    end
  endtask

  task automatic test_reset_abort;
    bit quiet;
    start_op(4'd5, 32'h1234, 32'd0);
    start_op(4'd6, 32'h5678, 32'd0);
    start_op(4'd3, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.E_MDUBusy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", bus.E_MDUBusy); end
    checks++; if (bus.E_HI !== 32'd0 || bus.E_LO !== 32'd0)
      begin errors++; $display("FAIL abort_hilo got %h_%h want 0_0", bus.E_HI, bus.E_LO); end
    @(negedge clk);
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < DC + 3; i++) begin
      @(negedge clk);
      if (bus.E_MDUBusy !== 1'b0 || bus.E_HI !== 32'd0 || bus.E_LO !== 32'd0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL abort_release got activity after reset want none"); end
    hi_m = '0; lo_m = '0;
  endtask

  initial begin
    test_reset;
    test_mt;
    test_mult;
    test_div;
    test_div_zero;
    test_busy_ignore;
    test_nop;
    test_madd;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for multiply ops.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for divide ops.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port E_MDUStart  input  1  op valid in E stage this cycle.
REQ-006 SHALL have port E_MDUOp  input  4  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9-15 NONE.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port E_MDUBusy  output  1  multi-cycle op in flight.
REQ-010 SHALL have port E_HI  output  32  HI register.
REQ-011 SHALL have port E_LO  output  32  LO register.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV; busy is high exactly in MUL and DIV.
REQ-013 SHALL accept an op only when E_MDUStart=1 and state=IDLE; start while busy is ignored (no state, operand or HI/LO change).
REQ-014 SHALL, on accepted MULT/MULTU/MADD/MADDU, latch A, B and op, load counter with MULT_CYCLES, enter MUL next edge.
REQ-015 SHALL, on accepted DIV/DIVU, latch A, B and op, load counter with DIV_CYCLES, enter DIV next edge.
REQ-016 SHALL decrement counter each busy cycle; on the edge where counter=1, write HI/LO and return to IDLE, so busy is high for exactly N cycles and new HI/LO are visible in the first cycle busy is low.
REQ-017 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; {HI,LO} = 64-bit product.
REQ-018 SHALL compute DIV signed (LO = quotient truncated toward zero, HI = remainder with sign of dividend) and DIVU unsigned.
REQ-019 SHALL, for divide with latched B=0, hold busy for DIV_CYCLES then leave HI and LO unchanged.
REQ-020 SHALL, for signed DIV of 0x80000000 by 0xFFFFFFFF, write LO=0x80000000, HI=0.
REQ-021 SHALL execute MTHI/MTLO in one cycle without busy: HI (or LO) = A at the accepting edge.
REQ-022 SHALL treat NONE and codes 9-15 as no-ops with no state change.
REQ-023 SHALL compute results from latched operands only; A/B changes during busy have no effect.
REQ-024 SHALL keep HI/LO stable during busy; intermediate values are never visible.

Reset
REQ-025 SHALL, on reset_n low at any time, asynchronously force state IDLE, counter 0, E_MDUBusy 0, E_HI 0, E_LO 0, latched operands 0.
REQ-026 SHALL abort an in-flight op on reset with no HI/LO write after reset_n rises.

Configuration
REQ-027 SHALL use macro MDU_MADD_EN: defined -> MADD/MADDU accumulate {HI,LO} = {HI,LO} + product (signed/unsigned, modulo 2^64) with MULT_CYCLES latency; undefined -> codes 7 and 8 are NONE (not accepted, no busy, HI/LO unchanged).

Verification
REQ-028 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 SHALL cover: DIVU A=100, B=7 -> busy high 10 cycles, then LO=14, HI=2; DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 SHALL cover: HI=0x11, LO=0x22, DIV A=5, B=0 -> busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-031 SHALL cover: MULTU started, second start (MTHI A=0x55) in busy cycle 2 -> ignored, final HI/LO = MULTU result only.
REQ-032 SHALL cover: DIV started, reset_n low in busy cycle 4 -> busy, HI, LO 0 immediately; no write after release.
REQ-033 SHALL cover: with MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0; without macro, same stimulus -> busy stays 0, HI/LO unchanged.
